regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (reg_write_en/dest/data) among NUM_REQ writeback sources, e.g. ALU, load unit and multiplier.
- Round-robin arbitration with valid/ready handshakes per requester.
- One registered output slot feeds the register file; a pipeline-freeze input holds that slot.
- Sits between the execute/memory writeback paths and the 32x32 register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_dest  input  NUM_REQ*ADDR_W  packed destination indices, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; the request transfers when valid&&ready
wb_stall  input  1  pipeline freeze; blocks the register-file write
reg_write_en  output  1  register-file write enable
reg_write_dest  output  ADDR_W  register-file write index
reg_write_data  output  DATA_W  register-file write data
wb_busy  output  1  output slot occupied (out_valid)

Behaviour:
- Reset values (async, rst=1): out_valid=0, out_dest=0, out_data=0, rr_ptr=0. All outputs are 0 while rst is high.
- can_accept = !out_valid || !wb_stall. The slot is either empty or draining this cycle.
- Arbitration (combinational):
  - Among requesters with req_valid=1, grant the first found searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[i]=1 only for the winner, and only when can_accept=1. Otherwise req_ready is all 0.
  - req_ready never depends on the requester's own ready-to-valid path. Requesters hold valid/dest/data stable until granted.
- rr_ptr update:
  - On a transfer by requester g: rr_ptr <= (g+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- Output slot on a transfer: out_valid<=1, out_dest<=winner dest, out_data<=winner data.
- If the slot drains (out_valid && !wb_stall) with no new transfer: out_valid<=0. out_dest/out_data hold their last values.
- Draining and a new transfer in the same cycle: the slot loads the new entry (back-to-back, 1 write/cycle sustained).
- reg_write_en = out_valid && !wb_stall && (out_dest != 0). reg_write_dest=out_dest, reg_write_data=out_data.
- Latency: transfer in cycle N produces a register-file write edge at the end of cycle N+1, if not stalled.
- Writes to x0 (dest 0): accepted and consume an arbitration slot. The slot drains normally but never asserts reg_write_en.
- wb_stall=1 with out_valid=1: the slot holds, reg_write_en=0, all req_ready=0. It resumes on the first cycle with wb_stall=0.
- wb_stall=1 with out_valid=0: one transfer is accepted into the empty slot, then the slot holds.
- Ordering: grants are totally ordered, so two writes to the same register reach the register file in grant order.
- Reset asserted mid-operation discards the pending slot entry; no write is issued.

Optional Feature:
- Macro: REGFILE_WB_PERF_CNT_EN.
- Defined:
  - Adds output perf_wait_cnt, NUM_REQ*16 bits.
  - Per-requester 16-bit counter increments each cycle req_valid[i] && !req_ready[i].
  - Saturates at 16'hFFFF; reset to 0 by rst.
- Not defined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0, and a wb_req typedef (dest, data).
- One sub-module, rr_arbiter: a parameterised round-robin one-hot grant from a request vector and pointer. It is reusable for other shared resources.

Test Plan:
- Reset: hold rst=1 with all req_valid=1 -> req_ready=0, reg_write_en=0, wb_busy=0. Release rst -> first grant goes to req 0.
- Round-robin: all 3 valid continuously with dests 1/2/3 and data A/B/C -> grants 0,1,2,0,…. reg_write_en=1 every cycle from cycle 2, dest sequence 1,2,3,1.
- Stall: slot holds dest 7 / data 0xDEADBEEF, wb_stall=1 for 4 cycles -> reg_write_en=0 and req_ready=0 throughout. First unstalled cycle writes 7/0xDEADBEEF, and a new grant is issued in that same cycle.
- x0 filter: req 1 writes dest 0 / data 0x1234 -> req_ready[1]=1 and wb_busy=1 next cycle, reg_write_en stays 0.
- Same-dest ordering: req 0 dest 5 = 0x11, then req 2 dest 5 = 0x22 granted later -> register-file writes occur 0x11 then 0x22.
- REGFILE_WB_PERF_CNT_EN: req 2 blocked 5 cycles by reqs 0/1 -> perf_wait_cnt[2] = 5. Force 70000 blocked cycles -> counter reads 0xFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the writeback request record
// used by the writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: searches the request vector from ptr upward,
// wrapping modulo N. Reusable for any shared resource.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  int               sum;
  logic [PTR_W-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = 0;
    sel       = '0;
    for (int off = 0; off < N; off++) begin
      sum = int'(ptr) + off;
      if (sum >= N) sum = sum - N;
      sel = PTR_W'(sum);
      if (!grant_any && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources.
// Optional per-requester wait counters: define REGFILE_WB_PERF_CNT_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  output logic                      reg_write_en,
  output logic [ADDR_W-1:0]         reg_write_dest,
  output logic [DATA_W-1:0]         reg_write_data,
  output logic                      wb_busy
`ifdef REGFILE_WB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]     perf_wait_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic               out_valid;
  logic [ADDR_W-1:0]  out_dest;
  logic [DATA_W-1:0]  out_data;
  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               can_accept;
  logic               xfer;
  logic [ADDR_W-1:0]  win_dest;
  logic [DATA_W-1:0]  win_data;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Slot is empty or draining this cycle; rst gates grants so outputs stay quiet.
  assign can_accept = !out_valid || !wb_stall;
  assign xfer       = grant_any && can_accept && !rst;
  assign req_ready  = (can_accept && !rst) ? grant : '0;

  assign win_dest = req_dest[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign win_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_dest  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_dest  <= win_dest;
        out_data  <= win_data;
        rr_ptr    <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + PTR_W'(1);
      end else if (!wb_stall) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign reg_write_en   = out_valid && !wb_stall && (out_dest != ADDR_W'(REG_ZERO));
  assign reg_write_dest = out_dest;
  assign reg_write_data = out_data;
  assign wb_busy        = out_valid;

`ifdef REGFILE_WB_PERF_CNT_EN
  logic [15:0] wait_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && !req_ready[i] && wait_cnt[i] != 16'hFFFF)
          wait_cnt[i] <= wait_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    perf_wait_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_wait_cnt[i*16 +: 16] = wait_cnt[i];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a transaction-level model checks
// every cycle, plus literal expectations on grant and write sequences.
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*5-1:0]  req_dest = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          wb_stall = 1'b0;
  logic          reg_write_en;
  logic [4:0]    reg_write_dest;
  logic [31:0]   reg_write_data;
  logic          wb_busy;
`ifdef REGFILE_WB_PERF_CNT_EN
  logic [N*16-1:0] perf_wait_cnt;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_dest       (req_dest),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .wb_stall       (wb_stall),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .wb_busy        (wb_busy)
`ifdef REGFILE_WB_PERF_CNT_EN
    ,
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: the slot as a single pending entry plus the next requester to favour.
  bit          m_valid = 0;
  logic [4:0]  m_dest  = '0;
  logic [31:0] m_data  = '0;
  int          m_ptr   = 0;

  int          grant_log[$];
  logic [36:0] wr_log[$];

  always @(negedge clk) begin
    int w;
    bit can;
    logic [N-1:0] exp_ready;
    bit exp_en;
    if (rst) begin
      chk("rst_ready", {61'd0, req_ready}, 64'd0);
      chk("rst_wen", {63'd0, reg_write_en}, 64'd0);
      chk("rst_busy", {63'd0, wb_busy}, 64'd0);
      m_valid = 0; m_dest = '0; m_data = '0; m_ptr = 0;
    end else begin
      can = !m_valid || !wb_stall;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      exp_ready = (can && w >= 0) ? N'(1 << w) : '0;
      exp_en    = m_valid && !wb_stall && (m_dest != 5'd0);
      chk("req_ready", {61'd0, req_ready}, {61'd0, exp_ready});
      chk("reg_write_en", {63'd0, reg_write_en}, {63'd0, exp_en});
      chk("wb_busy", {63'd0, wb_busy}, {63'd0, m_valid});
      if (m_valid) begin
        chk("wr_dest", {59'd0, reg_write_dest}, {59'd0, m_dest});
        chk("wr_data", {32'd0, reg_write_data}, {32'd0, m_data});
      end
      if (reg_write_en) wr_log.push_back({reg_write_dest, reg_write_data});
      if (can && w >= 0) begin
        grant_log.push_back(w);
        m_valid = 1;
        m_dest  = req_dest[w*5 +: 5];
        m_data  = req_data[w*32 +: 32];
        m_ptr   = (w + 1) % N;
      end else if (!wb_stall) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] d, input logic [31:0] x);
    req_valid[i] = v;
    req_dest[i*5 +: 5] = d;
    req_data[i*32 +: 32] = x;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    wr_log.delete();
  endtask

  initial begin
    // Reset with every requester asking.
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    repeat (3) step();
    chk("lit_rst_ready", {61'd0, req_ready}, 64'd0);
    rst = 1'b0;
    clear_logs();
    repeat (6) step();
    req_valid = '0;
    repeat (2) step();
    chk("lit_rr_count", {63'd0, grant_log.size() >= 4}, 64'd1);
    if (grant_log.size() >= 4) begin
      chk("lit_rr_g0", grant_log[0], 0);
      chk("lit_rr_g1", grant_log[1], 1);
      chk("lit_rr_g2", grant_log[2], 2);
      chk("lit_rr_g3", grant_log[3], 0);
    end
    chk("lit_rr_wcount", {63'd0, wr_log.size() >= 4}, 64'd1);
    if (wr_log.size() >= 4) begin
      chk("lit_rr_w0", {27'd0, wr_log[0]}, {27'd0, 5'd1, 32'hA});
      chk("lit_rr_w1", {59'd0, wr_log[1][36:32]}, 64'd2);
      chk("lit_rr_w2", {59'd0, wr_log[2][36:32]}, 64'd3);
      chk("lit_rr_w3", {59'd0, wr_log[3][36:32]}, 64'd1);
    end

    // Stall holds 7/DEADBEEF; the first free cycle writes it and grants req 1.
    clear_logs();
    set_req(0, 1'b1, 5'd7, 32'hDEADBEEF);
    step();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 5'd9, 32'h99);
    wb_stall = 1'b1;
    step();
    chk("lit_stall_ready", {61'd0, req_ready}, 64'd0);
    chk("lit_stall_wen", {63'd0, reg_write_en}, 64'd0);
    repeat (3) step();
    wb_stall = 1'b0;
    #1;
    chk("lit_unstall_wen", {63'd0, reg_write_en}, 64'd1);
    chk("lit_unstall_ready", {61'd0, req_ready}, 64'd2);
    step();
    req_valid[1] = 1'b0;
    repeat (2) step();
    chk("lit_stall_wcount", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("lit_stall_w0", {27'd0, wr_log[0]}, {27'd0, 5'd7, 32'hDEADBEEF});
      chk("lit_stall_w1", {27'd0, wr_log[1]}, {27'd0, 5'd9, 32'h99});
    end

    // Write to x0: accepted, slot busy, no register-file write.
    clear_logs();
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("lit_x0_ready", {61'd0, req_ready}, 64'd2);
    step();
    req_valid[1] = 1'b0;
    chk("lit_x0_busy", {63'd0, wb_busy}, 64'd1);
    chk("lit_x0_wen", {63'd0, reg_write_en}, 64'd0);
    repeat (2) step();
    chk("lit_x0_nowrites", wr_log.size(), 0);

    // Same destination from two requesters lands in grant order.
    clear_logs();
    set_req(0, 1'b1, 5'd5, 32'h11);
    step();
    req_valid[0] = 1'b0;
    set_req(2, 1'b1, 5'd5, 32'h22);
    step();
    req_valid[2] = 1'b0;
    repeat (3) step();
    chk("lit_order_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("lit_order_w0", {27'd0, wr_log[0]}, {27'd0, 5'd5, 32'h11});
      chk("lit_order_w1", {27'd0, wr_log[1]}, {27'd0, 5'd5, 32'h22});
    end

    // Two of three requesters active: the idle one is skipped.
    clear_logs();
    set_req(0, 1'b1, 5'd1, 32'hA0);
    set_req(2, 1'b1, 5'd3, 32'hC0);
    repeat (4) step();
    req_valid = '0;
    repeat (2) step();
    chk("lit_skip_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("lit_skip_g0", grant_log[0], 0);
      chk("lit_skip_g1", grant_log[1], 2);
      chk("lit_skip_g2", grant_log[2], 0);
      chk("lit_skip_g3", grant_log[3], 2);
    end

    // Reset while the slot holds an entry discards it.
    clear_logs();
    set_req(0, 1'b1, 5'd4, 32'h44);
    step();
    req_valid[0] = 1'b0;
    wb_stall = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("lit_midrst_busy", {63'd0, wb_busy}, 64'd0);
    step();
    step();
    rst = 1'b0;
    wb_stall = 1'b0;
    repeat (2) step();
    chk("lit_midrst_nowrites", wr_log.size(), 0);

`ifdef REGFILE_WB_PERF_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h1);
    step();
    req_valid[0] = 1'b0;
    wb_stall = 1'b1;
    set_req(2, 1'b1, 5'd2, 32'h2);
    repeat (5) step();
    wb_stall = 1'b0;
    step();
    chk("lit_perf_5", {48'd0, perf_wait_cnt[32 +: 16]}, 64'd5);
    chk("lit_perf_req0", {48'd0, perf_wait_cnt[0 +: 16]}, 64'd0);
    wb_stall = 1'b1;
    repeat (70000) step();
    chk("lit_perf_sat", {48'd0, perf_wait_cnt[32 +: 16]}, 64'hFFFF);
    req_valid = '0;
    wb_stall = 1'b0;
    repeat (3) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
